// File: rtl/bcd4digit_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_ctrl_pkg
//  Purpose  : Shared types and constants for the 4-digit repeated-subtraction
//             BCD converter sequencer.
//  Contents : state_t   - sequencer state encoding
//             BCD_DIGITS - number of decimal digits produced per conversion
//             BCD_MAX    - largest value that fits in BCD_DIGITS digits
//             DIVISOR    - radix applied by the datapath on each divide
//  Revision : 1.0 - initial release
// ============================================================================
package bcd_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      DIV    = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam int BCD_DIGITS = 4;
   localparam int BCD_MAX    = 9999;
   localparam int DIVISOR    = 10;

endpackage : bcd_ctrl_pkg
`default_nettype wire

// File: rtl/bcd4digit_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : bcd4digit_ctrl_if
//  Purpose  : Request and datapath-control bundle of the BCD sequencer.
//  Signals  : start/value_in      - conversion request (requester -> ctrl)
//             carry               - dividend >= 10 (datapath -> ctrl)
//             value_out           - value for the datapath load
//             load_value/divide/load_quotient - datapath strobes
//             busy/done/overflow/error - status
//  Modports : slave  - the sequencer side
//             master - the requester/datapath side
//  Revision : 1.0 - initial release
// ============================================================================
interface bcd4digit_ctrl_if #(
   parameter int VAL_W = 14
);
   logic             start;
   logic [VAL_W-1:0] value_in;
   logic             carry;
   logic [VAL_W-1:0] value_out;
   logic             load_value;
   logic             divide;
   logic             load_quotient;
   logic             busy;
   logic             done;
   logic             overflow;
   logic             error;

   modport slave (
      input  start, value_in, carry,
      output value_out, load_value, divide, load_quotient,
             busy, done, overflow, error
   );

   modport master (
      output start, value_in, carry,
      input  value_out, load_value, divide, load_quotient,
             busy, done, overflow, error
   );
endinterface : bcd4digit_ctrl_if
`default_nettype wire

// File: rtl/bcd4digit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bcd4digit_ctrl
//  Purpose  : Sequencer for a 4-digit repeated-subtraction BCD converter.
//             Accepts a request, buffers one pending request, loads the
//             datapath and issues divide / load_quotient strobes until four
//             digits are stored. A per-digit divide watchdog aborts runaway
//             conversions.
//  Ports    : clk  - system clock
//             rst  - synchronous active-high reset
//             bus  - bcd4digit_ctrl_if.slave (request, datapath, status)
//  Revision : 1.0 - initial release
// ============================================================================
module bcd4digit_ctrl
   import bcd_ctrl_pkg::*;
#(
   parameter int MAX_DIV = 2047,
   parameter int VAL_W   = 14
) (
   input  wire logic          clk,
   input  wire logic          rst,
   bcd4digit_ctrl_if.slave    bus
);

   localparam int c_DIV_W = $clog2(MAX_DIV + 1);

   state_t             r_state;
   state_t             w_next_state;

   logic [VAL_W-1:0]   r_value;
   logic               r_pend_vld;
   logic [VAL_W-1:0]   r_pend_val;
   logic [c_DIV_W-1:0] r_div_cnt;
   logic [1:0]         r_digit_cnt;
   logic               r_overflow;
   logic               r_error;

   logic               w_load;
   logic               w_divide;
   logic               w_load_q;
   logic               w_wd_fire;
   logic               w_take_pend;
   logic               w_take_start;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and datapath strobes
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_divide     = 1'b0;
      w_load_q     = 1'b0;
      w_wd_fire    = 1'b0;
      w_take_pend  = 1'b0;
      w_take_start = 1'b0;

      case (r_state)
         IDLE: begin
            // An already buffered request is served before a fresh strobe.
            if (r_pend_vld) begin
               w_take_pend  = 1'b1;
               w_next_state = LOAD;
            end else if (bus.start) begin
               w_take_start = 1'b1;
               w_next_state = LOAD;
            end
         end
         LOAD: begin
            w_load       = 1'b1;
            w_next_state = DIV;
         end
         DIV: begin
            if (bus.carry) begin
               // Suppress the divide that would exceed the budget and abort.
               if (r_div_cnt == c_DIV_W'(MAX_DIV)) begin
                  w_wd_fire    = 1'b1;
                  w_next_state = IDLE;
               end else begin
                  w_divide = 1'b1;
               end
            end else begin
               w_load_q = 1'b1;
               if (r_digit_cnt == 2'(BCD_DIGITS - 1)) begin
                  w_next_state = FINISH;
               end
            end
         end
         FINISH: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Request capture, pending buffer, counters and status flags
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_value     <= '0;
         r_pend_vld  <= 1'b0;
         r_pend_val  <= '0;
         r_div_cnt   <= '0;
         r_digit_cnt <= '0;
         r_overflow  <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_error <= w_wd_fire;

         if (w_take_pend) begin
            r_value <= r_pend_val;
         end else if (w_take_start) begin
            r_value <= bus.value_in;
         end

         // Any start not consumed directly lands in the buffer; latest wins.
         if (bus.start && !w_take_start) begin
            r_pend_vld <= 1'b1;
            r_pend_val <= bus.value_in;
         end else if (w_take_pend) begin
            r_pend_vld <= 1'b0;
         end

         if (w_load) begin
            r_overflow  <= (r_value > VAL_W'(BCD_MAX));
            r_div_cnt   <= '0;
            r_digit_cnt <= '0;
         end else if (w_divide) begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
         end else if (w_load_q) begin
            r_div_cnt   <= '0;
            r_digit_cnt <= r_digit_cnt + 2'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.value_out     = r_value;
   assign bus.load_value    = w_load;
   assign bus.divide        = w_divide;
   assign bus.load_quotient = w_load_q;
   assign bus.busy          = (r_state != IDLE);
   assign bus.done          = (r_state == FINISH);
   assign bus.overflow      = r_overflow;
   assign bus.error         = r_error;

endmodule : bcd4digit_ctrl
`default_nettype wire

// File: tb/tb_bcd4digit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd4digit_ctrl
//  Purpose  : Self-checking bench for bcd4digit_ctrl with a behavioural
//             repeated-subtraction datapath attached. A second instance uses
//             a small divide budget to exercise the watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd4digit_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bcd4digit_ctrl_if #(.VAL_W(14)) u_if  ();
   bcd4digit_ctrl_if #(.VAL_W(14)) u_wif ();

   bcd4digit_ctrl #(.MAX_DIV(2047), .VAL_W(14)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   bcd4digit_ctrl #(.MAX_DIV(100), .VAL_W(14)) dut_wd (
      .clk (clk),
      .rst (rst),
      .bus (u_wif.slave)
   );

   // Behavioural datapath: dividend, quotient counter, digit store.
   logic [13:0] dv = '0;
   logic [13:0] quo = '0;
   logic [1:0]  dig_idx = '0;
   logic [3:0]  digits [4];
   logic [13:0] wdv = '0;
   logic [13:0] wquo = '0;

   assign u_if.carry  = (dv >= 14'd10);
   assign u_wif.carry = (wdv >= 14'd10);

   always @(posedge clk) begin
      if (u_if.load_value) begin
         dv <= u_if.value_out; quo <= '0; dig_idx <= '0;
      end else if (u_if.divide) begin
         dv <= dv - 14'd10; quo <= quo + 14'd1;
      end else if (u_if.load_quotient) begin
         digits[dig_idx] <= dv[3:0]; dv <= quo; quo <= '0;
         dig_idx <= dig_idx + 2'd1;
      end
   end

   always @(posedge clk) begin
      if (u_wif.load_value) begin
         wdv <= u_wif.value_out; wquo <= '0;
      end else if (u_wif.divide) begin
         wdv <= wdv - 14'd10; wquo <= wquo + 14'd1;
      end else if (u_wif.load_quotient) begin
         wdv <= wquo; wquo <= '0;
      end
   end

   function automatic logic [15:0] packed_digits();
      return {digits[3], digits[2], digits[1], digits[0]};
   endfunction

   // -----------------------------------------------------------------------
   task automatic test_reset();
      logic [4:0] flags;
      int quiet_bad;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (u_if.value_out !== 14'd0 || u_if.busy !== 1'b0 || u_if.overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: value_out=%0d busy=%b ovf=%b required 0/0/0",
                  u_if.value_out, u_if.busy, u_if.overflow);
      end
      rst = 1'b0;
      // Start a conversion and reset it in the middle of DIV.
      u_if.start = 1'b1; u_if.value_in = 14'd1234;
      @(negedge clk);
      u_if.start = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (u_if.busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_pre_busy: busy=%b required 1", u_if.busy);
      end
      rst = 1'b1;
      @(negedge clk);
      flags = {u_if.load_value, u_if.divide, u_if.load_quotient, u_if.done, u_if.error};
      checks++;
      if (flags !== 5'b0) begin
         failures++;
         $display("FAIL reset_strobes: {ld,div,lq,done,err}=%b required 00000", flags);
      end
      checks++;
      if (u_if.busy !== 1'b0 || u_if.value_out !== 14'd0) begin
         failures++;
         $display("FAIL reset_mid_div: busy=%b value_out=%0d required 0/0",
                  u_if.busy, u_if.value_out);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      quiet_bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (u_if.load_value || u_if.divide || u_if.load_quotient || u_if.busy ||
             u_if.done || u_if.error)
            quiet_bad++;
      end
      checks++;
      if (quiet_bad != 0) begin
         failures++;
         $display("FAIL idle_quiet: active cycles=%0d required 0", quiet_bad);
      end
   endtask

   // -----------------------------------------------------------------------
   task automatic run_conv(input string name, input logic [13:0] v, input int exp_lat,
                           input logic [15:0] exp_dig, input int exp_div,
                           input logic exp_ovf);
      int e0, t, ndiv, nlq, nerr;
      logic got;
      ndiv = 0; nlq = 0; nerr = 0; got = 1'b0; t = 0;
      @(negedge clk);
      u_if.start = 1'b1; u_if.value_in = v; e0 = cyc + 1;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         if (cyc == e0) begin
            u_if.start = 1'b0;
            checks++;
            if (u_if.load_value !== 1'b1 || u_if.value_out !== v) begin
               failures++;
               $display("FAIL %s load: load_value=%b value_out=%0d required 1/%0d",
                        name, u_if.load_value, u_if.value_out, v);
            end
         end
         if (cyc == e0 + 1) begin
            checks++;
            if (u_if.overflow !== exp_ovf) begin
               failures++;
               $display("FAIL %s overflow_early: got %b required %b", name, u_if.overflow, exp_ovf);
            end
         end
         if (u_if.divide) ndiv++;
         if (u_if.load_quotient) nlq++;
         if (u_if.error) nerr++;
         if (u_if.done) begin got = 1'b1; t = cyc; end
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL %s timeout: done not seen, required at cycle offset %0d", name, exp_lat);
      end else begin
         checks++;
         if (t - e0 !== exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d required %0d", name, t - e0, exp_lat);
         end
         checks++;
         if (packed_digits() !== exp_dig) begin
            failures++;
            $display("FAIL %s digits: got %h required %h", name, packed_digits(), exp_dig);
         end
         checks++;
         if (ndiv != exp_div || nlq != 4 || nerr != 0) begin
            failures++;
            $display("FAIL %s strobes: div=%0d lq=%0d err=%0d required %0d/4/0",
                     name, ndiv, nlq, nerr, exp_div);
         end
         checks++;
         if (u_if.overflow !== exp_ovf || u_if.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s done_status: ovf=%b busy=%b required %b/1",
                     name, u_if.overflow, u_if.busy, exp_ovf);
         end
      end
      @(negedge clk);
      checks++;
      if (u_if.done !== 1'b0 || u_if.busy !== 1'b0) begin
         failures++;
         $display("FAIL %s after_done: done=%b busy=%b required 0/0", name, u_if.done, u_if.busy);
      end
   endtask

   // -----------------------------------------------------------------------
   task automatic test_watchdog();
      int e0, t, ndiv, ndone;
      logic got;
      ndiv = 0; ndone = 0; got = 1'b0; t = 0;
      @(negedge clk);
      u_wif.start = 1'b1; u_wif.value_in = 14'd1234; e0 = cyc + 1;
      for (int i = 0; i < 500 && !got; i++) begin
         @(negedge clk);
         if (cyc == e0) u_wif.start = 1'b0;
         if (u_wif.divide) ndiv++;
         if (u_wif.done) ndone++;
         if (u_wif.error) begin got = 1'b1; t = cyc; end
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL wd_timeout: error not seen, required at offset 102");
      end else begin
         checks++;
         if (ndiv != 100 || ndone != 0) begin
            failures++;
            $display("FAIL wd_counts: divides=%0d done=%0d required 100/0", ndiv, ndone);
         end
         checks++;
         if (t - e0 != 102 || u_wif.busy !== 1'b0) begin
            failures++;
            $display("FAIL wd_timing: offset=%0d busy=%b required 102/0", t - e0, u_wif.busy);
         end
      end
      @(negedge clk);
      checks++;
      if (u_wif.error !== 1'b0 || u_wif.busy !== 1'b0 || u_wif.done !== 1'b0) begin
         failures++;
         $display("FAIL wd_after: error=%b busy=%b done=%b required 0/0/0",
                  u_wif.error, u_wif.busy, u_wif.done);
      end
   endtask

   // -----------------------------------------------------------------------
   task automatic test_back_to_back();
      int e0, nload;
      logic got;
      @(negedge clk);
      u_if.start = 1'b1; u_if.value_in = 14'd42; e0 = cyc + 1;
      @(negedge clk);                        // LOAD of 42
      u_if.start = 1'b0;
      @(negedge clk);                        // e0+1
      @(negedge clk);                        // e0+2
      u_if.start = 1'b1; u_if.value_in = 14'd7;
      @(negedge clk);                        // e0+3
      u_if.value_in = 14'd9;
      @(negedge clk);                        // e0+4
      u_if.start = 1'b0;
      @(negedge clk);                        // e0+5
      checks++;
      if (u_if.value_out !== 14'd42 || u_if.busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_hold: value_out=%0d busy=%b required 42/1", u_if.value_out, u_if.busy);
      end
      repeat (4) @(negedge clk);             // e0+9
      checks++;
      if (u_if.done !== 1'b1 || packed_digits() !== 16'h0042) begin
         failures++;
         $display("FAIL b2b_first_done: done=%b digits=%h required 1/0042",
                  u_if.done, packed_digits());
      end
      @(negedge clk);                        // e0+10
      checks++;
      if (u_if.busy !== 1'b0 || u_if.load_value !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle_gap: busy=%b load_value=%b required 0/0",
                  u_if.busy, u_if.load_value);
      end
      @(negedge clk);                        // e0+11
      checks++;
      if (u_if.load_value !== 1'b1 || u_if.value_out !== 14'd9) begin
         failures++;
         $display("FAIL b2b_second_load: load_value=%b value_out=%0d required 1/9",
                  u_if.load_value, u_if.value_out);
      end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (u_if.done) got = 1'b1;
      end
      checks++;
      if (!got || cyc - e0 != 16 || packed_digits() !== 16'h0009) begin
         failures++;
         $display("FAIL b2b_second_done: seen=%b offset=%0d digits=%h required 1/16/0009",
                  got, cyc - e0, packed_digits());
      end
      nload = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (u_if.load_value) nload++;
      end
      checks++;
      if (nload != 0) begin
         failures++;
         $display("FAIL b2b_dropped: extra loads=%0d required 0", nload);
      end
   endtask

   // -----------------------------------------------------------------------
   initial begin
      u_if.start = 1'b0;  u_if.value_in = '0;
      u_wif.start = 1'b0; u_wif.value_in = '0;
      test_reset();
      run_conv("conv_1234",  14'd1234,  141,  16'h1234, 136,  1'b0);
      run_conv("conv_0",     14'd0,     5,    16'h0000, 0,    1'b0);
      run_conv("conv_9999",  14'd9999,  1112, 16'h9999, 1107, 1'b0);
      run_conv("conv_12345", 14'd12345, 1375, 16'h2345, 1370, 1'b1);
      run_conv("conv_1234b", 14'd1234,  141,  16'h1234, 136,  1'b0);
      test_watchdog();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_bcd4digit_ctrl
`default_nettype wire

// File: doc/bcd4digit_ctrl.md
Name: bcd4digit_ctrl

Overview:
Sequencer for the 4-digit repeated-subtraction BCD converter datapath. It accepts 14-bit conversion requests, buffers one pending request, and presents the value to the datapath. It then drives load_value / divide / load_quotient pulses until four digits are stored, and reports done, overflow and a divide-count watchdog error.

Parameters:
MAX_DIV, 2047, maximum divide pulses allowed per digit before error (worst legal case 1638)
VAL_W, 14, request value width

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, reset is synchronous and active-high
start  in  1  request strobe, sampled every cycle
value_in  in  VAL_W  value captured with start
carry  in  1  from datapath: 1 when datapath dividend >= 10
value_out  out  VAL_W  registered value driven to datapath value input
load_value  out  1  datapath load strobe
divide  out  1  datapath subtract-10 strobe
load_quotient  out  1  datapath store-digit strobe
busy  out  1  high from LOAD through FINISH
done  out  1  one-cycle pulse, conversion complete, digits valid
overflow  out  1  value of current/last conversion > 9999; held until next LOAD
error  out  1  one-cycle pulse, watchdog fired, conversion aborted

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE; all outputs 0, value_out 0; pending buffer empty; counters 0. Reset mid-conversion aborts with no done/error pulse.
- States: IDLE, LOAD, DIV, FINISH.
- IDLE: if pending valid -> take pending, go LOAD; else if start -> capture value_in, go LOAD. Pending has priority over a simultaneous start; that start goes to pending.
- LOAD (1 cycle): load_value=1; value_out already holds the captured value; overflow <= (value > 9999); digit_cnt<=0, div_cnt<=0; -> DIV.
- DIV: combinational strobes from carry. carry=1 -> divide=1, div_cnt++. carry=0 -> load_quotient=1, div_cnt<=0, digit_cnt++. After the 4th load_quotient (digit_cnt==3 when carry=0) -> FINISH. Exactly one of divide/load_quotient is high per DIV cycle.
- Watchdog: if carry=1 and div_cnt==MAX_DIV -> no divide pulse, error pulse next cycle, -> IDLE. Digits are partial and undefined.
- FINISH (1 cycle): done=1, busy=1 -> IDLE. done and error are mutually exclusive.
- Strobe exclusivity: at most one of load_value/divide/load_quotient is high in any cycle. All are 0 in IDLE/FINISH.
- start while busy: written into the 1-deep pending buffer. A newer start overwrites the pending value (latest wins). value_out is unaffected until that request reaches LOAD.
- Latency: start sampled at edge E0 (IDLE, empty pending) -> done high in cycle beginning E0 + 5 + q0+q1+q2+q3, where qk = floor(v/10^(k+1)).
- Back-to-back: pending request enters LOAD on the cycle after FINISH (one IDLE cycle).
- div_cnt width ceil(log2(MAX_DIV+1)); digit_cnt 2 bits.
- Values > 9999: conversion still runs; the thousands-digit slot receives the remainder and overflow=1.

Decomposition:
- Package bcd_ctrl_pkg: state enum (IDLE, LOAD, DIV, FINISH), BCD_DIGITS=4, BCD_MAX=9999, DIVISOR=10.
- Single module, no sub-module. The pending buffer is a valid bit plus a value register inline.

Test Plan:
- Reset and idle: hold rst 3 cycles mid-DIV -> all strobes/busy/done/error 0 next cycle; 20 idle cycles, no strobes.
- start with 1234, behavioural datapath model attached -> done at E0+141; digits 4,3,2,1; strobe counts 123+12+1+0 divides and 4 load_quotient; overflow 0.
- value 0 -> done at E0+5, four load_quotient, zero divides. Value 9999 -> done at E0+1112, all digits 9.
- Value 12345 -> overflow=1 from LOAD+1, done at E0+5+1234+123+12+1.
- MAX_DIV=100, value 1234 -> exactly 100 divides, error pulse, no done, state IDLE, busy 0.
- Pending: start(42), then during DIV start(7) and start(9) -> 42 completes, one IDLE cycle, LOAD with value_out=9; 7 is never converted.
